// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions for the HDMI channel transmitter and receiver:
// period modes, fixed code words and the stage-1 transition-minimisation encoder.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_GUARD = 2'd3
  } mode_e;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_BR = 10'b1011001100;  // channels 0 and 2
  localparam logic [9:0] GUARD_G  = 10'b0100110011;  // channel 1

  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    logic [9:0] c;
    case (a)
      4'h0: c = 10'b1010011100;
      4'h1: c = 10'b1001100011;
      4'h2: c = 10'b1011100100;
      4'h3: c = 10'b1011100010;
      4'h4: c = 10'b0101110001;
      4'h5: c = 10'b0100011110;
      4'h6: c = 10'b0110001110;
      4'h7: c = 10'b0100111100;
      4'h8: c = 10'b1011001100;
      4'h9: c = 10'b0100111001;
      4'hA: c = 10'b0110011100;
      4'hB: c = 10'b1011000110;
      4'hC: c = 10'b1010001110;
      4'hD: c = 10'b1001110001;
      4'hE: c = 10'b0101100011;
      default: c = 10'b1011000011;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // qm[8] = 1 marks XOR chaining, 0 marks XNOR chaining.
  function automatic logic [8:0] tm_encode(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/hdmi_channel_tx.sv
// Single-lane TMDS encoder: stage 1 does transition minimisation, stage 2 applies
// DC balance or substitutes control/TERC4/guard codes. One symbol per clock.
module hdmi_channel_tx
  import hdmi_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic [3:0] aux,
  output logic [9:0] tmds,
  output logic       tmds_valid
);

  // Stage 1
  logic [8:0] qm_q, qm_d;
  logic [3:0] n1_q, n0_q, n1_d;
  mode_e      mode_q;
  logic [1:0] ctrl_q;
  logic [3:0] aux_q;

  assign qm_d = tm_encode(data);
  assign n1_d = popcount8(qm_d[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q   <= '0;
      n1_q   <= '0;
      n0_q   <= '0;
      mode_q <= MODE_CTRL;
      ctrl_q <= '0;
      aux_q  <= '0;
    end else begin
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      n0_q   <= 4'd8 - n1_d;
      mode_q <= mode_e'(mode);
      ctrl_q <= ctrl;
      aux_q  <= aux;
    end
  end

  // Stage 2
  logic [9:0]        tmds_q, tmds_d;
  logic signed [4:0] cnt_q, cnt_d;
  logic signed [5:0] diff, cnt_w, sum;
  logic [1:0]        vld_pipe_q;
  logic              qm8;
  logic [7:0]        qm;

  assign qm8 = qm_q[8];
  assign qm  = qm_q[7:0];

  // 6-bit intermediates keep the disparity update free of 5-bit overflow.
  always_comb begin
    tmds_d = CTRL_00;
    cnt_d  = '0;
    diff   = $signed({2'b00, n1_q}) - $signed({2'b00, n0_q});
    cnt_w  = {cnt_q[4], cnt_q};
    sum    = '0;
    case (mode_q)
      MODE_CTRL: begin
        case (ctrl_q)
          2'b00:   tmds_d = CTRL_00;
          2'b01:   tmds_d = CTRL_01;
          2'b10:   tmds_d = CTRL_10;
          default: tmds_d = CTRL_11;
        endcase
      end
      MODE_TERC4: tmds_d = terc4_code(aux_q);
      MODE_GUARD: tmds_d = (CHANNEL == 1) ? GUARD_G : GUARD_BR;
      default: begin
        if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
          tmds_d = {~qm8, qm8, qm8 ? qm : ~qm};
          sum    = qm8 ? (cnt_w + diff) : (cnt_w - diff);
        end else if ((!cnt_q[4] && (n1_q > n0_q)) || (cnt_q[4] && (n0_q > n1_q))) begin
          tmds_d = {1'b1, qm8, ~qm};
          sum    = cnt_w + $signed({4'b0000, qm8, 1'b0}) - diff;
        end else begin
          tmds_d = {1'b0, qm8, qm};
          sum    = cnt_w - $signed({4'b0000, ~qm8, 1'b0}) + diff;
        end
        cnt_d = sum[4:0];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmds_q     <= CTRL_00;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      tmds_q     <= tmds_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
    end
  end

  assign tmds       = tmds_q;
  assign tmds_valid = vld_pipe_q[1];

endmodule
